// File: rtl/mini_alu_sched.sv
// Round-robin scheduler sharing one miniALU between two requesters.
// Grants a command, registers operands to the ALU, then returns the captured result with its requester id.
module mini_alu_sched #(
    parameter int OP_W  = 4,
    parameter int RES_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*OP_W-1:0] req_op1,
    input  logic [2*OP_W-1:0] req_op2,
    input  logic [1:0]        req_operation,
    input  logic [1:0]        req_sign,
    output logic [OP_W-1:0]   alu_op1,
    output logic [OP_W-1:0]   alu_op2,
    output logic              alu_operation,
    output logic              alu_sign,
    input  logic [RES_W-1:0]  alu_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RES_W-1:0]  resp_data,
    output logic              resp_id,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state;
    logic            rr_ptr;
    logic            id_q;
    logic            grant_vld;
    logic            grant_id;
    logic [OP_W-1:0] sel_op1;
    logic [OP_W-1:0] sel_op2;

    // Grant only in IDLE; contention is resolved by the round-robin pointer.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        req_ready = 2'b00;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0;   end
                2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1;   end
                2'b11:   begin grant_vld = 1'b1; grant_id = rr_ptr; end
                default: begin grant_vld = 1'b0; grant_id = 1'b0;   end
            endcase
            if (grant_vld)
                req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    assign sel_op1 = grant_id ? req_op1[2*OP_W-1:OP_W] : req_op1[OP_W-1:0];
    assign sel_op2 = grant_id ? req_op2[2*OP_W-1:OP_W] : req_op2[OP_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            id_q          <= 1'b0;
            alu_op1       <= '0;
            alu_op2       <= '0;
            alu_operation <= 1'b0;
            alu_sign      <= 1'b0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_id       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        alu_op1       <= sel_op1;
                        alu_op2       <= sel_op2;
                        alu_operation <= req_operation[grant_id];
                        alu_sign      <= req_sign[grant_id];
                        id_q          <= grant_id;
                        rr_ptr        <= ~grant_id;
                        state         <= ISSUE;
                        busy          <= 1'b1;
                    end
                end
                // ALU inputs have been stable for a full cycle; take its result.
                ISSUE: begin
                    resp_data  <= alu_result;
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
